// File: rtl/data_bus_io.sv
// Data-side bus slave: byte-writable data RAM plus an MMIO window holding
// a GPIO register, a FIFO-buffered 8N1 UART transmitter and a cycle counter.
module data_bus_io #(
  parameter int RAM_AW       = 10,
  parameter int GPIO_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              uart_txd_o
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  typedef enum logic [1:0] {
    REG_GPIO   = 2'd0,
    REG_TXDATA = 2'd1,
    REG_STAT   = 2'd2,
    REG_CYCLE  = 2'd3
  } mmio_reg_e;

  // Address decode and strobes
  logic              wr;
  logic              rd;
  logic              ram_hit;
  logic              mmio_hit;
  mmio_reg_e         reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_bits;

  assign wr       = mem_ce_i & mem_we_i & ~rst;
  assign rd       = mem_ce_i & ~mem_we_i & ~rst;
  assign ram_hit  = (mem_addr_i[31:28] == 4'h0);
  assign mmio_hit = (mem_addr_i[31:28] == 4'h1);
  assign reg_sel  = mmio_reg_e'(mem_addr_i[3:2]);
  assign ram_idx  = mem_addr_i[RAM_AW+1:2];

  assign unused_addr_bits = ^{mem_addr_i[27:RAM_AW+2], mem_addr_i[1:0]};

  logic gpio_we;
  logic push;
  logic stat_we;
  logic cycle_we;

  assign gpio_we  = wr & mmio_hit & (reg_sel == REG_GPIO) & (|mem_sel_i);
  assign push     = wr & mmio_hit & (reg_sel == REG_TXDATA) & mem_sel_i[0];
  assign stat_we  = wr & mmio_hit & (reg_sel == REG_STAT);
  assign cycle_we = wr & mmio_hit & (reg_sel == REG_CYCLE);

  // Data RAM
  logic [31:0] ram [2**RAM_AW];

  // NOTE: storage arrays carry no reset; contents survive rst and only the
  // write strobe (already gated by rst) can change them.
  always_ff @(posedge clk) begin
    if (wr && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_sel_i[i]) ram[ram_idx][8*i +: 8] <= mem_data_i[8*i +: 8];
      end
    end
  end

  // GPIO and cycle counter
  logic [31:0] cycle_q;

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_o  <= '0;
      cycle_q <= '0;
    end else begin
      if (gpio_we) gpio_o <= mem_data_i[GPIO_W-1:0];
      if (cycle_we) cycle_q <= mem_data_i;
      else          cycle_q <= cycle_q + 32'd1;
    end
  end

  // TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  uart_state_e      state;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign pop        = (state == IDLE) & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[tail] <= mem_data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) tail <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
      if (pop)     head <= (head == PTR_LAST) ? '0 : head + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stat_we)                    ovf <= 1'b0;
      else if (push && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  // UART transmitter; txd is registered with the level of the state being entered
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      uart_txd_o <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_txd_o <= 1'b1;
          if (pop) begin
            shift      <= fifo_mem[head];
            baud_cnt   <= '0;
            state      <= START;
            uart_txd_o <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= DATA;
            uart_txd_o <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state      <= STOP;
              uart_txd_o <= 1'b1;
            end else begin
              bit_idx    <= bit_idx + 1'b1;
              uart_txd_o <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Same-cycle read mux
  logic busy;

  assign busy = (state != IDLE);

  // NOTE: the default assignment up front keeps every path driven, so no
  // latch is inferred for mem_data_o.
  always_comb begin
    mem_data_o = '0;
    if (rd) begin
      if (ram_hit) begin
        mem_data_o = ram[ram_idx];
      end else if (mmio_hit) begin
        case (reg_sel)
          REG_GPIO:   mem_data_o[GPIO_W-1:0] = gpio_o;
          REG_TXDATA: mem_data_o = '0;
          REG_STAT:   mem_data_o = {28'b0, ovf, fifo_empty, fifo_full, busy};
          REG_CYCLE:  mem_data_o = cycle_q;
          default:    mem_data_o = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_bus_io.sv
// Bench for data_bus_io: directed bus sequences followed by random traffic,
// all checked against a frame-timing reference model of the bus slave.
module tb_data_bus_io;

  localparam int RAM_AW = 10;
  localparam int GPIO_W = 8;
  localparam int CPB    = 4;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CPB;

  localparam logic [31:0] GPIO_A = 32'h1000_0000;
  localparam logic [31:0] TX_A   = 32'h1000_0004;
  localparam logic [31:0] STAT_A = 32'h1000_0008;
  localparam logic [31:0] CYC_A  = 32'h1000_000C;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic [GPIO_W-1:0] gpio_o;
  logic              uart_txd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_io #(
    .RAM_AW      (RAM_AW),
    .GPIO_W      (GPIO_W),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ce_i  (mem_ce_i),
    .mem_we_i  (mem_we_i),
    .mem_sel_i (mem_sel_i),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o),
    .gpio_o    (gpio_o),
    .uart_txd_o(uart_txd_o)
  );

  // Reference model: the transmitter is described by when its current frame
  // started, the line level follows from the offset into that frame.
  longint      edge_no     = 0;
  longint      frame_start = -1000;
  logic [7:0]  cur_byte    = '0;
  logic [7:0]  fifo_q [$];
  bit          ovf_m       = 1'b0;
  logic [7:0]  gpio_m      = '0;
  logic [31:0] cycle_m     = '0;
  logic [31:0] ram_m [int unsigned];
  logic [9:0]  pool [8];

  function automatic bit busy_m();
    return (edge_no - frame_start) < FRAME;
  endfunction

  function automatic logic exp_txd();
    longint d = edge_no - frame_start;
    int     k;
    if (d >= FRAME) return 1'b1;
    k = int'(d / CPB);
    if (k == 0) return 1'b0;
    if (k <= 8) return cur_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model_read(input bit r, input bit ce, input bit we, input logic [31:0] a,
                            output logic [31:0] v, output bit known);
    int unsigned idx;
    v     = '0;
    known = 1'b1;
    if (r || !ce || we) return;
    if (a[31:28] == 4'h0) begin
      idx = int'(a[11:2]);
      if (ram_m.exists(idx)) v = ram_m[idx];
      else known = 1'b0;
    end else if (a[31:28] == 4'h1) begin
      case (a[3:2])
        2'd0: v = {24'b0, gpio_m};
        2'd2: v = {28'b0, ovf_m, fifo_q.size() == 0, fifo_q.size() == DEPTH, busy_m()};
        2'd3: v = cycle_m;
        default: v = '0;
      endcase
    end
  endtask

  task automatic model_update(input bit r, input bit ce, input bit we, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d);
    bit          wr_m;
    bit          mm;
    bit          was_full;
    bit          popped;
    int unsigned idx;
    edge_no++;
    if (r) begin
      fifo_q.delete();
      ovf_m       = 1'b0;
      gpio_m      = '0;
      cycle_m     = '0;
      frame_start = -1000;
      return;
    end
    wr_m     = ce && we;
    mm       = (a[31:28] == 4'h1);
    was_full = (fifo_q.size() == DEPTH);
    popped   = (edge_no > frame_start + FRAME) && (fifo_q.size() > 0);
    if (popped) begin
      cur_byte    = fifo_q.pop_front();
      frame_start = edge_no;
    end
    if (wr_m && mm && a[3:2] == 2'd1 && s[0]) begin
      if (was_full && !popped) ovf_m = 1'b1;
      else fifo_q.push_back(d[7:0]);
    end
    if (wr_m && mm && a[3:2] == 2'd2) ovf_m = 1'b0;
    if (wr_m && mm && a[3:2] == 2'd0 && s != 4'h0) gpio_m = d[7:0];
    if (wr_m && mm && a[3:2] == 2'd3) cycle_m = d;
    else cycle_m = cycle_m + 32'd1;
    if (wr_m && a[31:28] == 4'h0) begin
      idx = int'(a[11:2]);
      for (int i = 0; i < 4; i++) begin
        if (s[i]) ram_m[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_no, obs, exp);
    end
  endtask

  // One bus cycle: drive after the falling edge, check the combinational read
  // just before the rising edge, then check registered outputs after it.
  task automatic step(input bit r, input bit ce, input bit we, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit chk = 1'b0, input logic [31:0] want = '0, input string tag = "");
    logic [31:0] er;
    bit          known;
    rst        = r;
    mem_ce_i   = ce;
    mem_we_i   = we;
    mem_sel_i  = s;
    mem_addr_i = a;
    mem_data_i = d;
    #1;
    model_read(r, ce, we, a, er, known);
    if (known) check("rdata", mem_data_o, er);
    if (chk) check(tag, mem_data_o, want);
    @(posedge clk);
    model_update(r, ce, we, s, a, d);
    #1;
    check("txd", 32'(uart_txd_o), 32'(exp_txd()));
    check("gpio", 32'(gpio_o), 32'(gpio_m));
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1'b0, 1'b1, 1'b1, s, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, 1'b0, 4'hF, a, '0);
  endtask

  task automatic rdc(input logic [31:0] a, input logic [31:0] want, input string tag);
    step(1'b0, 1'b1, 1'b0, 4'hF, a, '0, 1'b1, want, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  function automatic logic [31:0] mmio_addr(input logic [1:0] rg);
    logic [31:0] a;
    a        = $urandom;
    a[31:28] = 4'h1;
    a[3:2]   = rg;
    return a;
  endfunction

  function automatic logic [31:0] ram_addr();
    logic [31:0] a;
    a        = $urandom;
    a[31:28] = 4'h0;
    a[11:2]  = pool[$urandom_range(0, 7)];
    return a;
  endfunction

  initial begin
    logic [9:0]  pat;
    int unsigned op;
    logic [31:0] a;
    logic [31:0] d;

    rst        = 1'b1;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_sel_i  = '0;
    mem_addr_i = '0;
    mem_data_i = '0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 4'hF, STAT_A, '0);
    step(1'b1, 1'b1, 1'b1, 4'hF, GPIO_A, 32'hFF);
    check("rst_txd", 32'(uart_txd_o), 32'h1);
    check("rst_gpio", 32'(gpio_o), 32'h0);
    rdc(CYC_A, 32'h0, "rst_cycle");
    rdc(STAT_A, 32'h4, "rst_stat");

    // RAM byte lanes
    wr(32'h0000_0100, 32'h1122_3344, 4'hF);
    wr(32'h0000_0100, 32'hAABB_CCDD, 4'h4);
    rdc(32'h0000_0100, 32'h11BB_3344, "ram_lanes");

    // GPIO load and sel=0 write
    wr(GPIO_A, 32'hFFFF_FFA5, 4'h1);
    check("gpio_load", 32'(gpio_o), 32'hA5);
    rdc(GPIO_A, 32'h0000_00A5, "gpio_read");
    wr(GPIO_A, 32'h0000_0012, 4'h0);
    check("gpio_nosel", 32'(gpio_o), 32'hA5);

    // Single UART frame of 0x55
    wr(TX_A, 32'h0000_0055, 4'h1);
    pat = 10'b10_1010_1010;
    for (int i = 0; i < FRAME; i++) begin
      rd(STAT_A);
      check("frame_bit", 32'(uart_txd_o), 32'(pat[i / CPB]));
    end
    idle(1);
    rdc(STAT_A, 32'h4, "stat_after_frame");

    // FIFO overflow: six back-to-back pushes while idle
    for (int i = 0; i < 6; i++) wr(TX_A, 32'hA0 + 32'(i), 4'h1);
    rdc(STAT_A, 32'hB, "stat_full_ovf");
    idle(215);
    rdc(STAT_A, 32'hC, "stat_ovf_sticky");
    wr(STAT_A, 32'h0, 4'h0);
    rdc(STAT_A, 32'h4, "stat_ovf_clear");

    // CYCLE load and wrap
    wr(CYC_A, 32'hFFFF_FFFE, 4'h0);
    rd(CYC_A);
    rdc(CYC_A, 32'hFFFF_FFFF, "cycle_max");
    rdc(CYC_A, 32'h0000_0000, "cycle_wrap");

    // Reset during DATA bit 3 with two bytes queued
    wr(TX_A, 32'hC0, 4'h1);
    wr(TX_A, 32'hC1, 4'h1);
    wr(TX_A, 32'hC2, 4'h1);
    idle(15);
    step(1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
    check("rst_mid_txd", 32'(uart_txd_o), 32'h1);
    check("rst_mid_gpio", 32'(gpio_o), 32'h0);
    rdc(CYC_A, 32'h0, "rst_mid_cycle");
    rdc(STAT_A, 32'h4, "rst_mid_stat");
    rdc(32'h0000_0100, 32'h11BB_3344, "ram_retained");

    // Random traffic
    for (int k = 0; k < 8; k++) begin
      pool[k] = 10'((k * 97 + 5) & 10'h3FF);
      a = $urandom;
      a[31:28] = 4'h0;
      a[11:2]  = pool[k];
      wr(a, $urandom, 4'hF);
    end
    for (int n = 0; n < 2500; n++) begin
      op = $urandom_range(0, 99);
      d  = $urandom;
      if ($urandom_range(0, 249) == 0) begin
        step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, d);
      end else if (op < 25) begin
        wr(mmio_addr(2'd1), d, 4'($urandom));
      end else if (op < 35) begin
        rd(mmio_addr(2'd2));
      end else if (op < 38) begin
        wr(mmio_addr(2'd2), d, 4'($urandom));
      end else if (op < 48) begin
        wr(ram_addr(), d, 4'($urandom));
      end else if (op < 58) begin
        rd(ram_addr());
      end else if (op < 64) begin
        wr(mmio_addr(2'd0), d, 4'($urandom));
      end else if (op < 69) begin
        rd(mmio_addr(2'd0));
      end else if (op < 72) begin
        if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        wr(mmio_addr(2'd3), d, 4'($urandom));
      end else if (op < 78) begin
        rd(mmio_addr(2'd3));
      end else if (op < 83) begin
        a = $urandom;
        a[31:28] = 4'($urandom_range(2, 15));
        step(1'b0, 1'b1, 1'($urandom), 4'($urandom), a, d);
      end else if (op < 85) begin
        rd(mmio_addr(2'd1));
      end else begin
        step(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
